// File: rtl/door_motor_plant.sv
// door_motor_plant: behavioural motorised door with upper/lower limit switches.
// Consumes Up_M/Dn_M motor commands, tracks a prescaled Position, drives
// Up_Max/Dn_Max back to the controller, and latches Fault on illegal drive.
// Ports: CLK, RST (async active-low), Up_M, Dn_M in;
//        Up_Max, Dn_Max, Position[POS_W], Moving, Fault out (all registered).
// Optional macro DOOR_PLANT_OBSTRUCT_EN adds input Obstruct, which freezes
// descent (prescaler and Position) while held in FALLING.
module door_motor_plant #(
    parameter int POS_MAX  = 100,
    parameter int POS_W    = 8,
    parameter int STEP_DIV = 4,
    parameter int OVR_LIM  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Up_M,
    input  logic             Dn_M,
`ifdef DOOR_PLANT_OBSTRUCT_EN
    input  logic             Obstruct,
`endif
    output logic             Up_Max,
    output logic             Dn_Max,
    output logic [POS_W-1:0] Position,
    output logic             Moving,
    output logic             Fault
);

    localparam int PRE_W = $clog2(STEP_DIV + 1);
    localparam int OVR_W = $clog2(OVR_LIM + 1);

    localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_MX1 = POS_W'(POS_MAX - 1);
    localparam logic [PRE_W-1:0] PRE_END = PRE_W'(STEP_DIV - 1);
    localparam logic [OVR_W-1:0] OVR_END = OVR_W'(OVR_LIM - 1);

    typedef enum logic [2:0] {
        S_AT_BOTTOM,
        S_AT_TOP,
        S_MID,
        S_RISING,
        S_FALLING,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [PRE_W-1:0]   r_pre;
    logic [OVR_W-1:0]   r_ovr;
    logic               r_up_max;
    logic               r_dn_max;
    logic               r_moving;
    logic               r_fault;

    state_t             w_state_nx;
    state_t             w_rest;
    logic [POS_W-1:0]   w_pos_nx;
    logic [PRE_W-1:0]   w_pre_nx;
    logic [OVR_W-1:0]   w_ovr_nx;
    logic               w_up;
    logic               w_dn;
    logic               w_both;
    logic               w_at_top;
    logic               w_at_bot;
    logic               w_obs;

`ifdef DOOR_PLANT_OBSTRUCT_EN
    assign w_obs = Obstruct;
`else
    assign w_obs = 1'b0;
`endif

    assign w_up     = Up_M & ~Dn_M;
    assign w_dn     = Dn_M & ~Up_M;
    assign w_both   = Up_M & Dn_M;
    assign w_at_top = (r_pos == P_MAX);
    assign w_at_bot = (r_pos == '0);

    // Where the door settles if motion stops at the current position.
    always_comb begin
        w_rest = S_MID;
        if (w_at_top) begin
            w_rest = S_AT_TOP;
        end else if (w_at_bot) begin
            w_rest = S_AT_BOTTOM;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_pre_nx   = r_pre;
        w_ovr_nx   = '0;
        case (r_state)
            S_AT_BOTTOM, S_MID, S_AT_TOP: begin
                w_pre_nx = '0;
                if (w_both) begin
                    w_state_nx = S_FAULT;
                end else if (w_up && !w_at_top) begin
                    w_state_nx = S_RISING;
                end else if (w_dn && !w_at_bot) begin
                    w_state_nx = S_FALLING;
                end else if (w_up || w_dn) begin
                    // Driving into the limit that is already closed.
                    if (r_ovr == OVR_END) begin
                        w_state_nx = S_FAULT;
                    end else begin
                        w_ovr_nx = r_ovr + 1'b1;
                    end
                end
            end
            S_RISING: begin
                if (w_both) begin
                    w_state_nx = S_FAULT;
                    w_pre_nx   = '0;
                end else if (w_up) begin
                    if (r_pre == PRE_END) begin
                        w_pos_nx = r_pos + 1'b1;
                        w_pre_nx = '0;
                        if (r_pos == P_MX1) begin
                            w_state_nx = S_AT_TOP;
                        end
                    end else begin
                        w_pre_nx = r_pre + 1'b1;
                    end
                end else if (w_dn) begin
                    // Reversal before the first step out of the bottom.
                    w_pre_nx   = '0;
                    w_state_nx = w_at_bot ? S_AT_BOTTOM : S_FALLING;
                end else begin
                    w_pre_nx   = '0;
                    w_state_nx = w_rest;
                end
            end
            S_FALLING: begin
                if (w_both) begin
                    w_state_nx = S_FAULT;
                    w_pre_nx   = '0;
                end else if (w_dn) begin
                    if (w_obs) begin
                        w_pre_nx = r_pre;
                    end else if (r_pre == PRE_END) begin
                        w_pos_nx = r_pos - 1'b1;
                        w_pre_nx = '0;
                        if (r_pos == POS_W'(1)) begin
                            w_state_nx = S_AT_BOTTOM;
                        end
                    end else begin
                        w_pre_nx = r_pre + 1'b1;
                    end
                end else if (w_up) begin
                    w_pre_nx   = '0;
                    w_state_nx = w_at_top ? S_AT_TOP : S_RISING;
                end else begin
                    w_pre_nx   = '0;
                    w_state_nx = w_rest;
                end
            end
            S_FAULT: begin
                w_state_nx = S_FAULT;
                w_pre_nx   = '0;
            end
            default: begin
                w_state_nx = S_FAULT;
                w_pre_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_AT_BOTTOM;
            r_pos    <= '0;
            r_pre    <= '0;
            r_ovr    <= '0;
            r_up_max <= 1'b0;
            r_dn_max <= 1'b1;
            r_moving <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pos    <= w_pos_nx;
            r_pre    <= w_pre_nx;
            r_ovr    <= w_ovr_nx;
            r_up_max <= (w_pos_nx == P_MAX);
            r_dn_max <= (w_pos_nx == '0);
            r_moving <= (w_state_nx == S_RISING) ||
                        (w_state_nx == S_FALLING);
            r_fault  <= (w_state_nx == S_FAULT);
        end
    end

    assign Position = r_pos;
    assign Up_Max   = r_up_max;
    assign Dn_Max   = r_dn_max;
    assign Moving   = r_moving;
    assign Fault    = r_fault;

endmodule

// File: tb/tb_door_motor_plant.sv
// tb_door_motor_plant: scoreboard bench for door_motor_plant.
// Directed travel/reversal/fault scenarios followed by random command runs.
module tb_door_motor_plant;

    localparam int PM = 10;
    localparam int PW = 8;
    localparam int SD = 2;
    localparam int OL = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Up_M = 1'b0;
    logic          Dn_M = 1'b0;
`ifdef DOOR_PLANT_OBSTRUCT_EN
    logic          Obstruct = 1'b0;
`endif
    logic          Up_Max;
    logic          Dn_Max;
    logic [PW-1:0] Position;
    logic          Moving;
    logic          Fault;

    always #5 CLK = ~CLK;

    door_motor_plant #(
        .POS_MAX (PM),
        .POS_W   (PW),
        .STEP_DIV(SD),
        .OVR_LIM (OL)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Up_M    (Up_M),
        .Dn_M    (Dn_M),
`ifdef DOOR_PLANT_OBSTRUCT_EN
        .Obstruct(Obstruct),
`endif
        .Up_Max  (Up_Max),
        .Dn_Max  (Dn_Max),
        .Position(Position),
        .Moving  (Moving),
        .Fault   (Fault)
    );

    typedef struct packed {
        logic [PW-1:0] pos;
        logic          up;
        logic          dn;
        logic          mv;
        logic          flt;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference door: integer position, direction of travel (+1/-1/0),
    // cycles spent toward the next step, and cycles pushed into a limit.
    int   m_pos = 0;
    int   m_dir = 0;
    int   m_phase = 0;
    int   m_ovr = 0;
    bit   m_flt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic void model_step(bit u, bit d, bit rs);
        int want;
        if (!rs) begin
            m_pos = 0; m_dir = 0; m_phase = 0; m_ovr = 0; m_flt = 0;
            return;
        end
        if (m_flt) return;
        if (u && d) begin
            m_flt = 1; m_dir = 0; m_phase = 0;
            return;
        end
        want = u ? 1 : (d ? -1 : 0);
        if (want == 0) begin
            m_dir = 0; m_phase = 0; m_ovr = 0;
            return;
        end
        if ((want > 0 && m_pos == PM) || (want < 0 && m_pos == 0)) begin
            if (m_dir == 0) begin
                m_ovr++;
                if (m_ovr >= OL) m_flt = 1;
            end else begin
                m_ovr = 0;
            end
            m_dir = 0; m_phase = 0;
            return;
        end
        m_ovr = 0;
        if (m_dir != want) begin
            m_dir = want; m_phase = 0;
            return;
        end
        m_phase++;
        if (m_phase == SD) begin
            m_pos += want;
            m_phase = 0;
            if (m_pos == 0 || m_pos == PM) m_dir = 0;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.pos = PW'(m_pos);
        o.up  = (m_pos == PM);
        o.dn  = (m_pos == 0);
        o.mv  = (m_dir != 0);
        o.flt = m_flt;
        return o;
    endfunction

    task automatic cycle(input bit u, input bit d, input bit rs);
        @(negedge CLK);
        Up_M = u;
        Dn_M = d;
        RST  = rs;
        @(posedge CLK);
        model_step(u, d, rs);
        exp_q.push_back(model_obs());
    endtask

    task automatic run(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(u, d, 1'b1);
    endtask

    task automatic rst_pulse();
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {Position, Up_Max, Dn_Max, Moving, Fault};
                chk("scoreboard", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        int r;
        int len;
        rst_pulse();
        rst_pulse();
        #2;
        chk("rst_pos", 32'(Position), 0);
        chk("rst_dnmax", 32'(Dn_Max), 1);
        chk("rst_upmax", 32'(Up_Max), 0);
        chk("rst_fault", 32'(Fault), 0);

        run(1, 0, 2);
        #2 chk("dnmax_held_e1", 32'(Dn_Max), 1);
        run(1, 0, 1);
        #2 chk("dnmax_fall_e2", 32'(Dn_Max), 0);
        run(1, 0, 8);
        #2 chk("pos_e10", 32'(Position), 5);
        chk("moving_e10", 32'(Moving), 1);
        run(1, 0, 10);
        #2 chk("pos_e20", 32'(Position), PM);
        chk("upmax_e20", 32'(Up_Max), 1);
        chk("moving_e20", 32'(Moving), 0);
        run(1, 0, 2);
        #2 chk("ovr_top_2", 32'(Fault), 0);
        run(1, 0, 1);
        #2 chk("ovr_top_3", 32'(Fault), 1);

        rst_pulse();
        run(0, 1, 2);
        run(0, 0, 1);
        run(0, 1, 2);
        #2 chk("ovr_bot_nofault", 32'(Fault), 0);
        run(0, 0, 1);

        run(1, 0, 21);
        run(0, 1, 7);
        #2 chk("fall_pos7", 32'(Position), 7);
        run(0, 0, 1);
        #2 chk("stop_moving", 32'(Moving), 0);
        chk("stop_pos", 32'(Position), 7);
        chk("stop_limits", 32'({Up_Max, Dn_Max}), 0);

        rst_pulse();
        run(1, 0, 10);
        run(0, 1, 1);
        #2 chk("rev_pos4", 32'(Position), 4);
        run(0, 1, 2);
        #2 chk("rev_pos3", 32'(Position), 3);

        rst_pulse();
        run(1, 0, 13);
        #2 chk("both_pre_pos", 32'(Position), 6);
        run(1, 1, 1);
        #2 chk("both_fault", 32'(Fault), 1);
        chk("both_moving", 32'(Moving), 0);
        run(1, 0, 5);
        #2 chk("fault_hold_pos", 32'(Position), 6);
        rst_pulse();
        #2 chk("post_rst_pos", 32'(Position), 0);
        chk("post_rst_dn", 32'(Dn_Max), 1);
        chk("post_rst_flt", 32'(Fault), 0);

        for (int b = 0; b < 160; b++) begin
            r   = int'($urandom_range(0, 99));
            len = int'($urandom_range(1, 30));
            if (m_flt && r < 60) rst_pulse();
            else if (r < 40) run(1, 0, len);
            else if (r < 80) run(0, 1, len);
            else if (r < 93) run(0, 0, len % 6 + 1);
            else if (r < 97) run(1, 1, 1);
            else rst_pulse();
        end

        @(posedge CLK);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/door_motor_plant.md
Name: door_motor_plant

Overview:
- Behavioural model of a motorised door plus its two limit switches: the sensor/actuator end of the door controller interface.
- Consumes motor commands Up_M/Dn_M. Tracks door position with a prescaled counter. Drives the Up_Max/Dn_Max limit signals back to the controller.
- Flags illegal drive conditions: both motor commands active, or driving into a limit for too long.
- Used as the closed-loop plant in controller benches and in FPGA demos with LED position readout.

Parameters:
- POS_MAX, 100: position count at fully open; 0 is fully closed; must be ≥2.
- POS_W, 8: width of Position; must hold POS_MAX.
- STEP_DIV, 4: clock cycles per one-count position step; ≥1.
- OVR_LIM, 8: consecutive cycles of drive into an active limit before fault; ≥1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- Up_M  input  1  motor drive open command.
- Dn_M  input  1  motor drive close command.
- Up_Max  output  1  upper limit switch: 1 iff Position==POS_MAX.
- Dn_Max  output  1  lower limit switch: 1 iff Position==0.
- Position  output  POS_W  current door position.
- Moving  output  1  1 while in RISING or FALLING.
- Fault  output  1  sticky fault flag.

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RST).
- All outputs are registered. On RST=0:
  - state=AT_BOTTOM
  - Position=0, Dn_Max=1, Up_Max=0, Moving=0, Fault=0
  - prescaler=0, overdrive counter=0
- States: AT_BOTTOM, AT_TOP, MID (stopped between limits), RISING, FALLING, FAULT.
- Command decode each edge: UP = Up_M&!Dn_M; DN = Dn_M&!Up_M; BOTH = Up_M&Dn_M; NONE otherwise.
- BOTH in any non-FAULT state: next state FAULT, Fault=1, Moving=0. Position holds.
- FAULT is exited only by reset. Limits keep reflecting Position while in FAULT.
- AT_BOTTOM / MID / AT_TOP:
  - UP with Position<POS_MAX: go RISING.
  - DN with Position>0: go FALLING.
  - On entry to RISING/FALLING: prescaler=0, Moving=1 on the same edge.
- RISING:
  - prescaler increments each edge.
  - On the edge where prescaler==STEP_DIV-1: Position+1 and prescaler=0.
  - If the new Position==POS_MAX: same edge sets state AT_TOP, Up_Max=1, Moving=0.
  - Dn_Max clears on the first step edge.
- FALLING: mirror of RISING. On reaching 0: AT_BOTTOM, Dn_Max=1, Moving=0.
- Stop and reversal:
  - NONE while moving: go MID (or the limit state if at a limit). prescaler=0, partial step discarded, Moving=0.
  - Opposite command while moving: switch direction directly, prescaler=0.
- Timing:
  - Command first sampled at edge k, from a stopped state: first position change at edge k+STEP_DIV.
  - Full travel 0→POS_MAX completes at edge k+POS_MAX*STEP_DIV.
- Overdrive:
  - In AT_TOP with UP, or AT_BOTTOM with DN: overdrive counter increments.
  - Counter reaching OVR_LIM: FAULT on that edge.
  - Counter clears on any other command or state.
- Position never wraps; it is saturated at 0 and POS_MAX by construction.
- Up_Max and Dn_Max are never both 1.

Optional Feature:
- Macro: DOOR_PLANT_OBSTRUCT_EN.
- Defined: adds input Obstruct (1 bit).
  - While Obstruct=1 in FALLING: prescaler and Position freeze, Moving stays 1.
  - Release of Obstruct resumes counting from the frozen prescaler value.
  - Obstruct has no effect in other states.
  - Overdrive detection is unchanged.
- Undefined: no Obstruct port; FALLING always progresses.

Test Plan:
Bench parameters: POS_MAX=10, STEP_DIV=2, OVR_LIM=3.
1. Reset, then hold Up_M=1 from edge 0 → Dn_Max falls at edge 2; Position=5 at edge 10; Up_Max=1, Moving=0, Position=10 at edge 20.
2. From top, Dn_M=1 for 7 edges then NONE → Position=7 at edge 6 (3 steps); state MID; Moving=0; Up_Max=0, Dn_Max=0.
3. Rising at Position=4 with prescaler=1, switch to Dn_M=1 → prescaler cleared; Position=3 two edges later.
4. Up_M=Dn_M=1 for one cycle while moving at Position=6 → Fault=1 next edge; Moving=0; Position stays 6 despite further commands until RST pulse, which restores Position=0, Dn_Max=1, Fault=0.
5. At top, hold Up_M=1 → Fault=1 on the 3rd edge. Same at bottom with Dn_M: 2 edges then release, no fault.
6. (DOOR_PLANT_OBSTRUCT_EN) Falling from 10, Obstruct=1 for 5 cycles at Position=8 → Position holds 8, Moving=1; descent resumes after release, reaching 0 five cycles later than unobstructed.
